// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the MAC dot-product sequencer:
//   - default operand / accumulator / term-counter widths and FIFO depth
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package mac_seq_pkg;

    localparam int DEF_DATA_W     = 4;  // operand width, matches MAC a/b
    localparam int DEF_ACC_W      = 8;  // accumulator / result width
    localparam int DEF_FIFO_DEPTH = 4;  // operand FIFO entries (power of two, >= 2)
    localparam int DEF_CNT_W      = 4;  // term counter width (saturating)

    // RUN   : pop operand pairs from the FIFO and issue them to the MAC
    // DRAIN : last term issued; MAC holds the full sum, wait for output slot
    // CLEAR : pulse mac_clr so the MAC starts the next vector from zero
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage : mac_seq_pkg

// File: rtl/mac_seq_fifo.sv
// -----------------------------------------------------------------------------
// mac_seq_fifo
// Synchronous FIFO holding operand pairs {last, a, b} for the sequencer.
// No write-to-read bypass: an entry written at edge k is readable in cycle k+1.
// Read data is the current head (show-ahead); rd_en_i pops it.
// A write while full is dropped, so callers gate writes with !full_o.
//
// Ports
//   clk_i      in   1      rising-edge clock
//   rst_i      in   1      asynchronous active-high reset (empties the FIFO)
//   wr_en_i    in   1      push request
//   wr_data_i  in   WIDTH  push data
//   rd_en_i    in   1      pop request (ignored when empty)
//   rd_data_o  out  WIDTH  head entry
//   full_o     out  1      no free entry
//   empty_o    out  1      no valid entry
// -----------------------------------------------------------------------------
module mac_seq_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one wrap bit above the index so full and empty differ.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule : mac_seq_fifo

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
// Feeder/controller for an external 4-bit accumulate MAC. Operand pairs are
// buffered in a FIFO, issued one per cycle to the MAC, and when the pair
// flagged last has been accumulated the MAC result is captured into a
// valid/ready output register. The MAC is then cleared for the next vector.
//
// Configuration macro
//   MAC_SEQ_OVF_EN  defined  : sticky MAC carry-out tracking drives res_ovf_o
//                   undefined: res_ovf_o is always 0, mac_cout_i is ignored
//
// Ports
//   clk_i         in   1       rising-edge clock
//   rst_i         in   1       asynchronous active-high reset
//   in_valid_i    in   1       operand pair valid
//   in_ready_o    out  1       FIFO not full
//   in_a_i        in   DATA_W  multiplicand
//   in_b_i        in   DATA_W  multiplier
//   in_last_i     in   1       pair is the final term of the vector
//   mac_a_o       out  DATA_W  MAC a (0 when not issuing)
//   mac_b_o       out  DATA_W  MAC b (0 when not issuing)
//   mac_cin_o     out  1       MAC carry-in, constant 0
//   mac_clr_o     out  1       registered clear pulse, ORed into MAC reset
//   mac_result_i  in   ACC_W   MAC accumulator
//   mac_cout_i    in   1       MAC adder carry-out
//   res_valid_o   out  1       dot-product result valid
//   res_ready_i   in   1       consumer accepts result
//   res_data_o    out  ACC_W   dot product mod 2**ACC_W
//   res_terms_o   out  CNT_W   number of terms (saturating)
//   res_ovf_o     out  1       accumulator wrapped during the vector
//
// Timing: last term issued in cycle c -> result valid from cycle c+2,
// MAC cleared in cycle c+2, next vector's first pop no earlier than c+3.
// -----------------------------------------------------------------------------
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic              in_last_i,
    output logic [DATA_W-1:0] mac_a_o,
    output logic [DATA_W-1:0] mac_b_o,
    output logic              mac_cin_o,
    output logic              mac_clr_o,
    input  logic [ACC_W-1:0]  mac_result_i,
    input  logic              mac_cout_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  res_data_o,
    output logic [CNT_W-1:0]  res_terms_o,
    output logic              res_ovf_o
);

    localparam int               ENTRY_W = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;

    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                head_last;
    logic [DATA_W-1:0]   head_a;
    logic [DATA_W-1:0]   head_b;
    logic                pop;
    logic                res_load;
    logic                ovf_flag;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mac_clr_q, mac_clr_d;
    logic                res_valid_q, res_valid_d;
    logic [ACC_W-1:0]    res_data_q, res_data_d;
    logic [CNT_W-1:0]    res_terms_q, res_terms_d;
    logic                res_ovf_q, res_ovf_d;

    // ---------------------------------------------------------------------
    // Operand FIFO
    // ---------------------------------------------------------------------
    assign fifo_wdata = {in_last_i, in_a_i, in_b_i};
    assign {head_last, head_a, head_b} = fifo_rdata;

    mac_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (in_valid_i),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Full blocks input even if a pop happens in the same cycle.
    assign in_ready_o = !fifo_full;

    // Pops only happen in RUN; DRAIN and CLEAR issue zero operands so the
    // MAC accumulator stays put while the result waits for its slot.
    assign pop = (state_q == ST_RUN) && !fifo_empty;

    // The output register may load when it is empty or being emptied now.
    assign res_load = (state_q == ST_DRAIN) && (!res_valid_q || res_ready_i);

    assign mac_a_o   = pop ? head_a : '0;
    assign mac_b_o   = pop ? head_b : '0;
    assign mac_cin_o = 1'b0;
    assign mac_clr_o = mac_clr_q;

    // ---------------------------------------------------------------------
    // FSM next state, term counter and clear pulse
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (pop) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                    if (head_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_load) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // Registered so the pulse is glitch-free while it sits on MAC reset.
        mac_clr_d = (state_d == ST_CLEAR);
    end

    // ---------------------------------------------------------------------
    // Result output register
    // ---------------------------------------------------------------------
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_terms_d = res_terms_q;
        res_ovf_d   = res_ovf_q;
        if (res_valid_q && res_ready_i) res_valid_d = 1'b0;
        // A reload on the handshake edge takes priority over the drop.
        if (res_load) begin
            res_valid_d = 1'b1;
            res_data_d  = mac_result_i;
            res_terms_d = cnt_q;
            res_ovf_d   = ovf_flag;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky accumulator-overflow flag (optional)
    // ---------------------------------------------------------------------
`ifdef MAC_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Carry-out is only meaningful while a product is being added or the
    // MAC is idling on its final sum; bubbles in RUN add zero anyway.
    always_comb begin
        ovf_d = ovf_q;
        if (pop || (state_q == ST_DRAIN)) ovf_d = ovf_q | mac_cout_i;
        if (state_q == ST_CLEAR)          ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_flag = ovf_q;
`else
    logic unused_cout;
    assign unused_cout = mac_cout_i;
    assign ovf_flag    = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            // Held high through reset so the MAC leaves reset already cleared.
            mac_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_terms_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mac_clr_q   <= mac_clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_terms_q <= res_terms_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_terms_o = res_terms_q;
    assign res_ovf_o   = res_ovf_q;

endmodule : mac_dot_sequencer

// File: tb/tb_mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_sequencer
// Self-checking bench for mac_dot_sequencer. A behavioural MAC (registered
// accumulator, cleared by rst or mac_clr) closes the loop. Expected results
// are computed from the pushed operands and queued; a monitor pops and
// compares them on every result handshake and checks that a stalled result
// stays stable.
// -----------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;
    localparam int CNT_W  = 4;

`ifdef MAC_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] terms;
        logic             ovf;
    } res_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_a_i;
    logic [DATA_W-1:0] in_b_i;
    logic              in_last_i;
    logic [DATA_W-1:0] mac_a_o;
    logic [DATA_W-1:0] mac_b_o;
    logic              mac_cin_o;
    logic              mac_clr_o;
    logic [ACC_W-1:0]  mac_result_i;
    logic              mac_cout_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [ACC_W-1:0]  res_data_o;
    logic [CNT_W-1:0]  res_terms_o;
    logic              res_ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    res_t exp_q[$];

    // Push-side model of the vector in progress.
    int unsigned m_sum   = 0;
    int unsigned m_terms = 0;
    bit          m_wrap  = 1'b0;

    always #5 clk_i = ~clk_i;

    mac_dot_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_a_i       (in_a_i),
        .in_b_i       (in_b_i),
        .in_last_i    (in_last_i),
        .mac_a_o      (mac_a_o),
        .mac_b_o      (mac_b_o),
        .mac_cin_o    (mac_cin_o),
        .mac_clr_o    (mac_clr_o),
        .mac_result_i (mac_result_i),
        .mac_cout_i   (mac_cout_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_terms_o  (res_terms_o),
        .res_ovf_o    (res_ovf_o)
    );

    // ---------------------------------------------------------------------
    // Behavioural MAC
    // ---------------------------------------------------------------------
    logic [ACC_W-1:0] mac_acc;
    logic [ACC_W:0]   mac_sum;

    assign mac_sum      = {1'b0, mac_acc} + (9'(mac_a_o) * 9'(mac_b_o)) + 9'(mac_cin_o);
    assign mac_result_i = mac_acc;
    assign mac_cout_i   = mac_sum[ACC_W];

    always @(posedge clk_i) begin
        if (rst_i || mac_clr_o) mac_acc <= '0;
        else                    mac_acc <= mac_sum[ACC_W-1:0];
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic score_result();
        res_t e;
        if (exp_q.size() == 0) begin
            check("spurious_result", res_valid_o, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("res_data",  res_data_o,  e.data);
            check("res_terms", res_terms_o, e.terms);
            check("res_ovf",   res_ovf_o,   e.ovf);
        end
    endtask

    // Monitor: score each handshake, and check a stalled result is stable.
    logic hold_pend;
    res_t held;

    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", res_valid_o, 1'b1);
                check("hold_data",  res_data_o,  held.data);
                check("hold_terms", res_terms_o, held.terms);
            end
            if (res_valid_o && res_ready_i) score_result();
            hold_pend <= res_valid_o && !res_ready_i;
            held      <= {res_data_o, res_terms_o, res_ovf_o};
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic last);
        res_t e;
        int   guard = 0;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_a_i     = a;
        in_b_i     = b;
        in_last_i  = last;
        while (in_ready_o !== 1'b1 && guard < 300) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 300) begin
            check("in_ready_timeout", in_ready_o, 1'b1);
            in_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        m_sum = m_sum + int'(a) * int'(b);
        if (m_sum >= 256) begin
            m_sum  = m_sum - 256;
            m_wrap = 1'b1;
        end
        if (m_terms < 15) m_terms++;
        if (last) begin
            e.data  = 8'(m_sum);
            e.terms = 4'(m_terms);
            e.ovf   = OVF_EN ? m_wrap : 1'b0;
            exp_q.push_back(e);
            m_sum   = 0;
            m_terms = 0;
            m_wrap  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(3);
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_a_i      = '0;
        in_b_i      = '0;
        in_last_i   = 1'b0;
        res_ready_i = 1'b1;

        // Reset state
        idle(3);
        check("rst_in_ready",  in_ready_o,  1'b1);
        check("rst_mac_a",     mac_a_o,     0);
        check("rst_mac_b",     mac_b_o,     0);
        check("rst_mac_cin",   mac_cin_o,   1'b0);
        check("rst_mac_clr",   mac_clr_o,   1'b1);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_res_data",  res_data_o,  0);
        check("rst_res_terms", res_terms_o, 0);
        check("rst_res_ovf",   res_ovf_o,   1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("clr_after_rst", mac_clr_o, 1'b0);

        // Basic vector: 15 + 14 + 225 = 254
        push(4'd3, 4'd5, 1'b0);
        push(4'd2, 4'd7, 1'b0);
        push(4'd15, 4'd15, 1'b1);
        wait_drain();

        // Accumulator wrap: 450 mod 256 = 194
        push(4'd15, 4'd15, 1'b0);
        push(4'd15, 4'd15, 1'b1);
        wait_drain();

        // Back-pressure: first result held, second vector stalls in DRAIN,
        // then fill the FIFO until in_ready drops.
        @(posedge clk_i);
        #1 res_ready_i = 1'b0;
        push(4'd1, 4'd1, 1'b1);
        push(4'd2, 4'd2, 1'b1);
        idle(8);
        check("stall_valid", res_valid_o, 1'b1);
        check("stall_data",  res_data_o,  1);
        push(4'd1, 4'd2, 1'b1);
        push(4'd2, 4'd3, 1'b1);
        push(4'd0, 4'd5, 1'b1);
        push(4'd7, 4'd1, 1'b1);
        @(negedge clk_i);
        check("full_in_ready", in_ready_o, 1'b0);
        check("full_res_data", res_data_o, 1);
        @(posedge clk_i);
        #1 res_ready_i = 1'b1;
        wait_drain();

        // Single term with zero product, then a vector with bubbles
        push(4'd0, 4'd9, 1'b1);
        push(4'd2, 4'd3, 1'b0);
        idle(3);
        push(4'd4, 4'd1, 1'b0);
        idle(2);
        push(4'd1, 4'd1, 1'b1);
        wait_drain();

        // Reset mid-vector: partial sum and count must be discarded
        push(4'd5, 4'd5, 1'b0);
        push(4'd6, 4'd6, 1'b0);
        idle(3);
        rst_i   = 1'b1;
        m_sum   = 0;
        m_terms = 0;
        m_wrap  = 1'b0;
        @(negedge clk_i);
        check("midrst_res_valid", res_valid_o, 1'b0);
        check("midrst_in_ready",  in_ready_o,  1'b1);
        check("midrst_mac_clr",   mac_clr_o,   1'b1);
        idle(1);
        rst_i = 1'b0;
        push(4'd4, 4'd4, 1'b1);
        wait_drain();

        // 20-term vector: terms saturate at 15, sum 20
        for (int i = 0; i < 20; i++) push(4'd1, 4'd1, (i == 19));
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mac_dot_sequencer
